// File: rtl/muldiv_issue_ctrl_pkg.sv
// Shared definitions for the RV32M multiply/divide issue controller:
// funct3 encodings, unit op-select base, FSM state and debug view.
package muldiv_issue_ctrl_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [4:0] MD_OP_BASE = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  typedef struct packed {
    state_t state;
    logic   kill;
    logic   unit_busy;
  } dbg_t;

  function automatic logic [4:0] md_op_sel_of(input logic [2:0] funct3);
    return MD_OP_BASE | {2'b00, funct3};
  endfunction

endpackage

// File: rtl/muldiv_issue_ctrl_if.sv
// Issue-port, mul/div-unit and CDB signals of the issue controller.
// Handshakes: req accepted when req_valid & req_ready; CDB transfer when cdb_valid & cdb_ready.
interface muldiv_issue_ctrl_if #(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 5
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*3-1:0]     req_funct3;
  logic [NUM_REQ*32-1:0]    req_a;
  logic [NUM_REQ*32-1:0]    req_b;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic [NUM_REQ-1:0]       req_ready;

  logic        md_op_valid;
  logic [4:0]  md_op_sel;
  logic [31:0] md_rs1;
  logic [31:0] md_rs2;
  logic        md_busy;
  logic        md_done;
  logic [31:0] md_result;

  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             cdb_ready;

  // master is the controller; slave is the reservation stations, unit and CDB.
  modport master (
    input  req_valid, req_funct3, req_a, req_b, req_tag,
    output req_ready,
    output md_op_valid, md_op_sel, md_rs1, md_rs2,
    input  md_busy, md_done, md_result,
    output cdb_valid, cdb_tag, cdb_data,
    input  cdb_ready
  );

  modport slave (
    output req_valid, req_funct3, req_a, req_b, req_tag,
    input  req_ready,
    input  md_op_valid, md_op_sel, md_rs1, md_rs2,
    output md_busy, md_done, md_result,
    input  cdb_valid, cdb_tag, cdb_data,
    output cdb_ready
  );
endinterface

// File: rtl/muldiv_issue_ctrl_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or above ptr, wrapping,
// reported as a one-hot grant plus its encoded index.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] idx,
  output logic             found
);

  always_comb begin
    int j;
    logic [PTR_W-1:0] jj;
    j     = 0;
    jj    = '0;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      j  = (int'(ptr) + i) % N;
      jj = PTR_W'(j);
      if (!found && req[jj]) begin
        found     = 1'b1;
        grant[jj] = 1'b1;
        idx       = jj;
      end
    end
  end

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// Issue controller for the shared RV32M mul/div unit: round-robin grant,
// one op in flight, result buffered for the CDB, squash on flush.
module muldiv_issue_ctrl
  import muldiv_issue_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  muldiv_issue_ctrl_if.master   bus,
  input  logic                  flush,
  output logic                  ctrl_busy,
  output logic                  err_timeout,
  output dbg_t                  dbg
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t               state;
  logic [PTR_W-1:0]     rr_ptr;
  logic                 kill;
  logic [CNT_W-1:0]     wait_cnt;
  logic [TAG_W-1:0]     tag_q;
  logic                 cdb_valid_q;

  logic [NUM_REQ-1:0]   grant;
  logic [PTR_W-1:0]     grant_idx;
  logic                 grant_found;
  logic                 take;
  logic [PTR_W-1:0]     ptr_next;

  logic [2:0]           sel_funct3;
  logic [31:0]          sel_a;
  logic [31:0]          sel_b;
  logic [TAG_W-1:0]     sel_tag;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .found (grant_found)
  );

  assign take     = (state == ST_IDLE) && !flush && grant_found;
  assign ptr_next = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    sel_funct3 = '0;
    sel_a      = '0;
    sel_b      = '0;
    sel_tag    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_funct3 = bus.req_funct3[i*3 +: 3];
        sel_a      = bus.req_a[i*32 +: 32];
        sel_b      = bus.req_b[i*32 +: 32];
        sel_tag    = bus.req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  // Grant and CDB valid are combinational so a flush masks them in the same cycle.
  assign bus.req_ready = (take && rst_n) ? grant : '0;
  assign bus.cdb_valid = cdb_valid_q && !flush;
  assign ctrl_busy     = (state != ST_IDLE);

  assign dbg.state     = state;
  assign dbg.kill      = kill;
  assign dbg.unit_busy = bus.md_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      rr_ptr          <= '0;
      kill            <= 1'b0;
      wait_cnt        <= '0;
      tag_q           <= '0;
      cdb_valid_q     <= 1'b0;
      err_timeout     <= 1'b0;
      bus.md_op_valid <= 1'b0;
      bus.md_op_sel   <= '0;
      bus.md_rs1      <= '0;
      bus.md_rs2      <= '0;
      bus.cdb_tag     <= '0;
      bus.cdb_data    <= '0;
    end else begin
      bus.md_op_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (take) begin
            bus.md_op_sel   <= md_op_sel_of(sel_funct3);
            bus.md_rs1      <= sel_a;
            bus.md_rs2      <= sel_b;
            tag_q           <= sel_tag;
            rr_ptr          <= ptr_next;
            bus.md_op_valid <= 1'b1;
            state           <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_cnt <= '0;
          if (flush) kill <= 1'b1;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt != CNT_W'(TIMEOUT)) wait_cnt <= wait_cnt + 1'b1;
          if (wait_cnt == CNT_W'(TIMEOUT)) err_timeout <= 1'b1;
          // The unit cannot be aborted: a squashed op still runs to md_done.
          if (bus.md_done) begin
            if (kill || flush) begin
              kill  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              bus.cdb_data <= bus.md_result;
              bus.cdb_tag  <= tag_q;
              cdb_valid_q  <= 1'b1;
              state        <= ST_WB;
            end
          end else if (flush) begin
            kill <= 1'b1;
          end
        end
        ST_WB: begin
          if (flush || bus.cdb_ready) begin
            cdb_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Directed scoreboard bench for muldiv_issue_ctrl with a behavioural RV32M unit.
module tb_muldiv_issue_ctrl;
  import muldiv_issue_ctrl_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int TAG_W   = 5;
  localparam int TIMEOUT = 64;
  localparam int MD_W    = 5 + 32 + 32;
  localparam int CDB_W   = TAG_W + 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic ctrl_busy;
  logic err_timeout;
  dbg_t dbg;

  muldiv_issue_ctrl_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) bus ();

  muldiv_issue_ctrl #(
    .NUM_REQ (NUM_REQ),
    .TAG_W   (TAG_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .flush       (flush),
    .ctrl_busy   (ctrl_busy),
    .err_timeout (err_timeout),
    .dbg         (dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int failures = 0;
  int grant_cnt = 0;
  int cdb_cnt = 0;
  bit unit_en = 1'b1;
  int unit_lat = 4;

  logic [NUM_REQ-1:0] exp_grant_q[$];
  logic [MD_W-1:0]    exp_md_q[$];
  logic [CDB_W-1:0]   exp_cdb_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event not seen within cycle budget", name);
  endtask

  function automatic logic [31:0] rv32m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (f3)
      F3_MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      F3_MULH:   begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
      F3_MULHSU: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return p[63:32]; end
      F3_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      F3_DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return $signed(a) / $signed(b);
      end
      F3_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F3_REM:    begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  // behavioural mul/div unit
  initial begin
    logic [31:0] r;
    bus.md_busy   = 1'b0;
    bus.md_done   = 1'b0;
    bus.md_result = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.md_op_valid && unit_en) begin
        r = rv32m(bus.md_op_sel[2:0], bus.md_rs1, bus.md_rs2);
        bus.md_busy = 1'b1;
        repeat (unit_lat) @(posedge clk);
        #1;
        bus.md_done   = 1'b1;
        bus.md_result = r;
        @(posedge clk);
        #1;
        bus.md_done = 1'b0;
        bus.md_busy = 1'b0;
      end
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if ((bus.req_valid & bus.req_ready) != '0) begin
        grant_cnt++;
        if (exp_grant_q.size() == 0) timeout_fail("grant_unexpected");
        else check("grant", bus.req_ready, exp_grant_q.pop_front());
      end
      if (bus.md_op_valid) begin
        if (exp_md_q.size() == 0) timeout_fail("md_launch_unexpected");
        else check("md_launch", {bus.md_op_sel, bus.md_rs1, bus.md_rs2}, exp_md_q.pop_front());
      end
      if (bus.cdb_valid && bus.cdb_ready) begin
        cdb_cnt++;
        if (exp_cdb_q.size() == 0) timeout_fail("cdb_unexpected");
        else check("cdb_bcast", {bus.cdb_tag, bus.cdb_data}, exp_cdb_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic set_port(input int p, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [TAG_W-1:0] tag);
    bus.req_funct3[p*3 +: 3]       = f3;
    bus.req_a[p*32 +: 32]          = a;
    bus.req_b[p*32 +: 32]          = b;
    bus.req_tag[p*TAG_W +: TAG_W]  = tag;
    bus.req_valid[p]               = 1'b1;
  endtask

  task automatic wait_grant(input int p);
    bit ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      ok = bus.req_valid[p] && bus.req_ready[p];
    end
    if (!ok) timeout_fail($sformatf("grant_wait_port%0d", p));
  endtask

  task automatic wait_cdb_valid();
    bit ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      ok = bus.cdb_valid;
    end
    if (!ok) timeout_fail("cdb_valid_wait");
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = !ctrl_busy;
    end
    if (!ok) timeout_fail("idle_wait");
  endtask

  task automatic wait_cdb_count(input int target);
    bit ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = (cdb_cnt >= target);
    end
    if (!ok) timeout_fail("cdb_count_wait");
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bit saw_cdb;
    int g0;
    int c0;
    bus.req_valid  = '0;
    bus.req_funct3 = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_tag    = '0;
    bus.cdb_ready  = 1'b0;

    // reset state, with requests pending to show req_ready is masked
    bus.req_valid = 2'b11;
    #12;
    check("reset_outputs", {bus.req_ready, bus.md_op_valid, bus.md_op_sel, bus.md_rs1, bus.md_rs2,
                            bus.cdb_valid, bus.cdb_tag, bus.cdb_data, ctrl_busy, err_timeout}, 0);
    check("reset_state", dbg.state, ST_IDLE);
    bus.req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single MUL on port 0
    exp_grant_q.push_back(2'b01);
    exp_md_q.push_back({5'h10, 32'd7, 32'd6});
    exp_cdb_q.push_back({5'd3, 32'd42});
    @(posedge clk);
    #1 set_port(0, F3_MUL, 32'd7, 32'd6, 5'd3);
    wait_grant(0);
    @(posedge clk);
    #1 bus.req_valid = '0;
    @(negedge clk);
    check("t1_op_pulse_on", bus.md_op_valid, 1'b1);
    @(negedge clk);
    check("t1_op_pulse_off", bus.md_op_valid, 1'b0);
    check("t1_op_sel_held", bus.md_op_sel, 5'h10);
    wait_cdb_valid();
    @(negedge clk);
    check("t1_cdb_held", {bus.cdb_valid, bus.cdb_tag, bus.cdb_data}, {1'b1, 5'd3, 32'd42});
    @(posedge clk);
    #1 bus.cdb_ready = 1'b1;
    @(posedge clk);
    #1 bus.cdb_ready = 1'b0;
    wait_idle();

    // both ports requesting continuously: grants alternate 0,1,0
    do_reset();
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        exp_grant_q.push_back(2'b10);
        exp_md_q.push_back({5'h16, 32'd100, 32'd7});
        exp_cdb_q.push_back({5'd2, 32'd2});
      end else begin
        exp_grant_q.push_back(2'b01);
        exp_md_q.push_back({5'h14, 32'd100, 32'd7});
        exp_cdb_q.push_back({5'd1, 32'd14});
      end
    end
    g0 = grant_cnt;
    c0 = cdb_cnt;
    @(posedge clk);
    #1;
    set_port(0, F3_DIV, 32'd100, 32'd7, 5'd1);
    set_port(1, F3_REM, 32'd100, 32'd7, 5'd2);
    bus.cdb_ready = 1'b1;
    begin
      bit ok = 1'b0;
      for (int n = 0; n < 100 && !ok; n++) begin
        @(negedge clk);
        ok = (grant_cnt >= g0 + 3);
      end
      if (!ok) timeout_fail("t2_three_grants");
    end
    @(posedge clk);
    #1 bus.req_valid = '0;
    wait_cdb_count(c0 + 3);
    @(posedge clk);
    #1 bus.cdb_ready = 1'b0;
    wait_idle();

    // flush during WAIT of a DIVU: result dropped, no CDB traffic
    exp_grant_q.push_back(2'b01);
    exp_md_q.push_back({5'h15, 32'hFFFF_FFFF, 32'd1});
    @(posedge clk);
    #1 set_port(0, F3_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd4);
    wait_grant(0);
    @(posedge clk);
    #1 bus.req_valid = '0;
    @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("t3_in_wait", dbg.state, ST_WAIT);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("t3_kill_set", dbg.kill, 1'b1);
    saw_cdb = 1'b0;
    begin
      bit ok = 1'b0;
      for (int n = 0; n < 30 && !ok; n++) begin
        @(negedge clk);
        saw_cdb = saw_cdb | bus.cdb_valid;
        ok = !ctrl_busy;
      end
      if (!ok) timeout_fail("t3_return_idle");
    end
    check("t3_no_cdb", saw_cdb, 1'b0);
    check("t3_kill_cleared", dbg.kill, 1'b0);
    exp_grant_q.push_back(2'b10);
    exp_md_q.push_back({5'h10, 32'd3, 32'd5});
    exp_cdb_q.push_back({5'd6, 32'd15});
    c0 = cdb_cnt;
    @(posedge clk);
    #1;
    set_port(1, F3_MUL, 32'd3, 32'd5, 5'd6);
    bus.cdb_ready = 1'b1;
    wait_grant(1);
    @(posedge clk);
    #1 bus.req_valid = '0;
    wait_cdb_count(c0 + 1);
    @(posedge clk);
    #1 bus.cdb_ready = 1'b0;
    wait_idle();

    // WB held with cdb_ready low for 5 cycles; port 1 requesting meanwhile
    exp_grant_q.push_back(2'b01);
    exp_md_q.push_back({5'h13, 32'h8000_0000, 32'd4});
    exp_cdb_q.push_back({5'd9, 32'd2});
    @(posedge clk);
    #1 set_port(0, F3_MULHU, 32'h8000_0000, 32'd4, 5'd9);
    wait_grant(0);
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    set_port(1, F3_REMU, 32'd10, 32'd3, 5'd11);
    wait_cdb_valid();
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t4_wb_hold_%0d", i), {bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.req_ready},
            {1'b1, 5'd9, 32'd2, 2'b00});
      @(posedge clk);
      #1;
      if (i == 4) begin
        bus.req_valid = '0;
        bus.cdb_ready = 1'b1;
      end
      if (i == 5) bus.cdb_ready = 1'b0;
      if (i < 5) @(negedge clk);
    end
    @(negedge clk);
    check("t4_back_idle", {ctrl_busy, bus.cdb_valid}, 2'b00);

    // flush and cdb_ready in the same WB cycle: flush wins
    exp_grant_q.push_back(2'b10);
    exp_md_q.push_back({5'h17, 32'd10, 32'd3});
    @(posedge clk);
    #1 set_port(1, F3_REMU, 32'd10, 32'd3, 5'd11);
    wait_grant(1);
    @(posedge clk);
    #1 bus.req_valid = '0;
    wait_cdb_valid();
    check("t5_wb_data", {bus.cdb_tag, bus.cdb_data}, {5'd11, 32'd1});
    @(posedge clk);
    #1;
    flush = 1'b1;
    bus.cdb_ready = 1'b1;
    #1;
    check("t5_cdb_gated", bus.cdb_valid, 1'b0);
    check("t5_still_wb", dbg.state, ST_WB);
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.cdb_ready = 1'b0;
    #1;
    check("t5_idle", dbg.state, ST_IDLE);

    // unit never completes: sticky timeout, then async reset mid-WAIT
    unit_en = 1'b0;
    exp_grant_q.push_back(2'b01);
    exp_md_q.push_back({5'h10, 32'd1, 32'd1});
    @(posedge clk);
    #1 set_port(0, F3_MUL, 32'd1, 32'd1, 5'd12);
    wait_grant(0);
    @(posedge clk);
    #1 bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    check("t6_enter_wait", dbg.state, ST_WAIT);
    repeat (63) @(negedge clk);
    check("t6_err_before", err_timeout, 1'b0);
    repeat (2) @(negedge clk);
    check("t6_err_set", err_timeout, 1'b1);
    repeat (3) @(negedge clk);
    check("t6_err_sticky", {err_timeout, dbg.state}, {1'b1, ST_WAIT});
    @(posedge clk);
    #1 bus.req_valid = 2'b11;
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_reset_outputs", {bus.req_ready, bus.md_op_valid, bus.md_op_sel, bus.md_rs1, bus.md_rs2,
                                     bus.cdb_valid, bus.cdb_tag, bus.cdb_data, ctrl_busy, err_timeout}, 0);
    check("t6_async_reset_state", dbg.state, ST_IDLE);
    bus.req_valid = '0;
    unit_en = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // final report
    check("grant_q_drained", exp_grant_q.size(), 0);
    check("md_q_drained", exp_md_q.size(), 0);
    check("cdb_q_drained", exp_cdb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_issue_ctrl.md
Name: muldiv_issue_ctrl

Overview:
- Scheduler and sequencer for the single shared multi-cycle RV32M multiply/divide unit in the OoO integer cluster.
- Arbitrates round-robin between NUM_REQ reservation-station issue ports and launches one operation at a time into the unit.
- Tracks the ROB tag of the operation in flight, buffers the result, and presents it to the CDB with a valid/ready handshake.
- Squashes in-flight work on pipeline flush.

Parameters:
- NUM_REQ, 2, number of requesting issue ports (>=1).
- TAG_W, 5, ROB tag width.
- TIMEOUT, 64, max cycles in WAIT before the sticky error flag is set.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-port request
- req_funct3  in  NUM_REQ*3  M-op select, packed; 000 MUL ... 111 REMU
- req_a  in  NUM_REQ*32  rs1 operand, packed
- req_b  in  NUM_REQ*32  rs2 operand, packed
- req_tag  in  NUM_REQ*TAG_W  ROB tag, packed
- req_ready  out  NUM_REQ  one-hot grant; request accepted when valid&ready
- md_op_valid  out  1  start pulse to mul/div unit
- md_op_sel  out  5  5'b10000 + funct3
- md_rs1  out  32  latched operand A
- md_rs2  out  32  latched operand B
- md_busy  in  1  unit busy
- md_done  in  1  one-cycle completion pulse
- md_result  in  32  unit result, valid with md_done
- cdb_valid  out  1  result ready for broadcast
- cdb_tag  out  TAG_W  tag of result
- cdb_data  out  32  result
- cdb_ready  in  1  CDB grant
- flush  in  1  squash all outstanding M-ops
- ctrl_busy  out  1  state != IDLE
- err_timeout  out  1  sticky; set when the WAIT counter reaches TIMEOUT

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr_ptr=0, kill=0, wait_cnt=0. All outputs 0 (req_ready, md_op_valid, md_op_sel, md_rs1, md_rs2, cdb_*, ctrl_busy, err_timeout).
- FSM states: IDLE, ISSUE, WAIT, WB.
- IDLE:
  - req_ready is the one-hot round-robin pick among req_valid, searching from rr_ptr upward with wrap; it is combinational and only asserted in IDLE.
  - If a pick exists and flush=0: latch funct3, a, b and tag from the granted port; rr_ptr <= granted index+1 (mod NUM_REQ); go to ISSUE.
  - If flush=1: req_ready=0 and no grant.
- ISSUE:
  - md_op_valid=1 for exactly this cycle; md_op_sel, md_rs1 and md_rs2 are driven from latches and stay stable through WAIT.
  - Next state WAIT; wait_cnt cleared.
- WAIT:
  - wait_cnt increments each cycle, saturating.
  - When wait_cnt==TIMEOUT: err_timeout <= 1. It is sticky until reset, and the FSM stays in WAIT.
  - On md_done: if kill=1 or flush=1, discard md_result, clear kill, go to IDLE. Otherwise latch md_result into cdb_data and go to WB.
- WB:
  - cdb_valid=1; cdb_tag and cdb_data are held stable until the handshake.
  - cdb_valid & cdb_ready -> IDLE. The next grant is possible in the following cycle (no same-cycle re-grant).
  - flush=1 in WB: cdb_valid drops the same cycle (combinationally gated), go to IDLE, result discarded.
- Flush in ISSUE or WAIT sets kill=1. The unit cannot be aborted, so the controller waits for md_done and drops the result.
- flush and cdb_ready in the same WB cycle: flush wins, so no broadcast counts. The CDB must qualify with flush.
- Latency: request accept (cycle 0) -> md_op_valid (cycle 1) -> md_done at unit latency L -> cdb_valid the cycle after md_done. Best-case throughput is one op per L+3 cycles.
- md_done outside WAIT is ignored. md_busy is informational only and is not used for sequencing.
- Width: md_op_sel = {2'b10, funct3}.

Decomposition:
- Shared package holds:
  - M-op funct3 constants (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
  - MD_OP_BASE = 5'b10000.
  - FSM state encoding.
- One sub-module: rr_arbiter (NUM_REQ requests, pointer input, one-hot grant plus encoded index output), reusable by other shared units.

Test Plan:
- Single op, port0, MUL, a=7, b=6, tag=3, unit latency 4 -> md_op_valid one cycle with op_sel=0x10; cdb_valid with tag=3, data=42; held until cdb_ready.
- Both ports valid every cycle (NUM_REQ=2), DIV 100/7 tag 1 on port0, REM 100/7 tag 2 on port1 -> grants alternate port0, port1, port0; CDB data 14 then 2.
- Flush during WAIT of DIVU a=0xFFFFFFFF, b=1 -> md_done result dropped; no cdb_valid; next request granted after return to IDLE.
- WB with cdb_ready held low for 5 cycles, then high -> cdb_tag and cdb_data stable for 6 cycles; req_ready=0 throughout.
- Flush and cdb_ready asserted in the same WB cycle -> cdb_valid=0 that cycle; state returns to IDLE; no broadcast.
- Unit never asserts md_done, TIMEOUT=64 -> err_timeout rises 64 cycles after entering WAIT and stays high; async rst_n low mid-WAIT -> all outputs 0 immediately and the FSM is in IDLE.
